// File: rtl/draw_race_timer.sv
// Race timer overlay: counts MM:SS:FF from frame ticks and draws it over the pixel stream.
// Build option RACE_TIMER_BG_EN puts a solid black plate behind the text box.
module draw_race_timer #(
    parameter int          XPOS           = 16,
    parameter int          YPOS           = 16,
    parameter logic [11:0] TEXT_COLOR     = 12'hFFF,
    parameter int          FRAMES_PER_SEC = 60
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic [10:0] hcount_in,
    input  logic [10:0] vcount_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        hblnk_in,
    input  logic        vblnk_in,
    input  logic [11:0] rgb_in,
    input  logic        frame_tick,
    input  logic        run,
    input  logic        clear,
    input  logic [7:0]  char_pixels,
    output logic [10:0] char_addr,
    output logic [10:0] hcount_out,
    output logic [10:0] vcount_out,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        hblnk_out,
    output logic        vblnk_out,
    output logic [11:0] rgb_out,
    output logic [23:0] time_bcd
);

    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

    typedef struct packed {
        logic [10:0] hcount;
        logic [10:0] vcount;
        logic        hsync;
        logic        vsync;
        logic        hblnk;
        logic        vblnk;
        logic [11:0] rgb;
    } timing_t;

    localparam logic [3:0]  F_MAX1 = 4'((FRAMES_PER_SEC - 1) / 10);
    localparam logic [3:0]  F_MAX0 = 4'((FRAMES_PER_SEC - 1) % 10);
    localparam logic [11:0] X_LO   = 12'(XPOS);
    localparam logic [11:0] X_HI   = 12'(XPOS + 63);
    localparam logic [11:0] Y_LO   = 12'(YPOS);
    localparam logic [11:0] Y_HI   = 12'(YPOS + 15);

    state_t      state_q, state_d;
    logic [23:0] time_q, time_d, time_inc;
    logic [23:0] disp_q, disp_d;
    logic        at_max;

    logic [3:0] m1, m0, s1, s0, f1, f0;
    assign {m1, m0, s1, s0, f1, f0} = time_q;

    // BCD carry chain FF -> SS -> MM
    always_comb begin
        time_inc = time_q;
        if (f1 == F_MAX1 && f0 == F_MAX0) begin
            time_inc[7:0] = 8'h00;
            if (s1 == 4'd5 && s0 == 4'd9) begin
                time_inc[15:8] = 8'h00;
                if (m0 == 4'd9) begin
                    time_inc[19:16] = 4'd0;
                    time_inc[23:20] = m1 + 4'd1;
                end else begin
                    time_inc[19:16] = m0 + 4'd1;
                end
            end else if (s0 == 4'd9) begin
                time_inc[11:8]  = 4'd0;
                time_inc[15:12] = s1 + 4'd1;
            end else begin
                time_inc[11:8] = s0 + 4'd1;
            end
        end else if (f0 == 4'd9) begin
            time_inc[3:0] = 4'd0;
            time_inc[7:4] = f1 + 4'd1;
        end else begin
            time_inc[3:0] = f0 + 4'd1;
        end
    end

    assign at_max = (time_q[23:8] == 16'h9959) && (f1 == F_MAX1) && (f0 == F_MAX0);

    always_comb begin
        state_d = state_q;
        time_d  = time_q;
        if (clear) begin
            state_d = IDLE;
            time_d  = 24'h000000;
        end else begin
            case (state_q)
                IDLE, HOLD: if (run) state_d = RUN;
                RUN: begin
                    if (!run) state_d = HOLD;
                    if (frame_tick && !at_max) time_d = time_inc;
                end
                default: state_d = IDLE;
            endcase
        end
        disp_d = vblnk_in ? time_q : disp_q;
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            state_q <= IDLE;
            time_q  <= 24'h000000;
            disp_q  <= 24'h000000;
        end else begin
            state_q <= state_d;
            time_q  <= time_d;
            disp_q  <= disp_d;
        end
    end

    assign time_bcd = time_q;

    // Character codes of the eight box cells, taken from the frame snapshot
    logic [6:0] char_codes [8];
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_chars
            if (gi == 2 || gi == 5) begin : g_colon
                assign char_codes[gi] = 7'h3A;
            end else begin : g_digit
                localparam int NIB = (gi < 2) ? 5 - gi : (gi < 5) ? 6 - gi : 7 - gi;
                assign char_codes[gi] = {3'b011, disp_q[NIB*4 +: 4]};
            end
        end
    endgenerate

    timing_t     s1_q, s1_d, s2_q, s2_d;
    logic [10:0] char_addr_q, char_addr_d;
    logic [2:0]  s1_col_q, s1_col_d, s2_col_q, s2_col_d;
    logic        s1_in_box_q, s1_in_box_d, s2_in_box_q, s2_in_box_d;
    logic [5:0]  rx;
    logic [3:0]  ry;

    // Only the low bits of the local coordinates are needed; those do not depend on the high bits
    assign rx = hcount_in[5:0] - 6'(XPOS);
    assign ry = vcount_in[3:0] - 4'(YPOS);

    always_comb begin
        s1_in_box_d = ({1'b0, hcount_in} >= X_LO) && ({1'b0, hcount_in} <= X_HI) &&
                      ({1'b0, vcount_in} >= Y_LO) && ({1'b0, vcount_in} <= Y_HI);
        s1_col_d    = rx[2:0];
        char_addr_d = s1_in_box_d ? {char_codes[rx[5:3]], ry} : 11'h000;
        s1_d        = '{hcount: hcount_in, vcount: vcount_in, hsync: hsync_in,
                        vsync: vsync_in, hblnk: hblnk_in, vblnk: vblnk_in, rgb: rgb_in};
        s2_d        = s1_q;
        s2_col_d    = s1_col_q;
        s2_in_box_d = s1_in_box_q;
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            s1_q        <= '0;
            s2_q        <= '0;
            char_addr_q <= 11'h000;
            s1_col_q    <= 3'd0;
            s2_col_q    <= 3'd0;
            s1_in_box_q <= 1'b0;
            s2_in_box_q <= 1'b0;
        end else begin
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            char_addr_q <= char_addr_d;
            s1_col_q    <= s1_col_d;
            s2_col_q    <= s2_col_d;
            s1_in_box_q <= s1_in_box_d;
            s2_in_box_q <= s2_in_box_d;
        end
    end

    // The font row arrives alongside stage 2, so the final pick is combinational on it
    always_comb begin
        rgb_out = s2_q.rgb;
        if (s2_q.hblnk || s2_q.vblnk) begin
            rgb_out = 12'h000;
        end else if (s2_in_box_q && char_pixels[~s2_col_q]) begin
            rgb_out = TEXT_COLOR;
        end else begin
`ifdef RACE_TIMER_BG_EN
            if (s2_in_box_q) rgb_out = 12'h000;
`else
            rgb_out = s2_q.rgb;
`endif
        end
    end

    assign char_addr  = char_addr_q;
    assign hcount_out = s2_q.hcount;
    assign vcount_out = s2_q.vcount;
    assign hsync_out  = s2_q.hsync;
    assign vsync_out  = s2_q.vsync;
    assign hblnk_out  = s2_q.hblnk;
    assign vblnk_out  = s2_q.vblnk;

endmodule

// File: tb/tb_draw_race_timer.sv
// Directed bench for draw_race_timer with a registered font ROM model; a second
// instance with FRAMES_PER_SEC=2 reaches timer saturation in a short run.
module tb_draw_race_timer;

    logic        pclk = 1'b0;
    logic        rst = 1'b1;
    logic [10:0] hcount_in = '0, vcount_in = '0;
    logic        hsync_in = 1'b0, vsync_in = 1'b0, hblnk_in = 1'b0, vblnk_in = 1'b0;
    logic [11:0] rgb_in = '0;
    logic        frame_tick = 1'b0, run = 1'b0, clear = 1'b0;
    logic [7:0]  char_pixels = 8'h00;
    logic [7:0]  char_pixels2 = 8'h00;
    logic [10:0] char_addr, hcount_out, vcount_out;
    logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
    logic [11:0] rgb_out;
    logic [23:0] time_bcd;
    logic [10:0] char_addr2, hcount_out2, vcount_out2;
    logic        hsync_out2, vsync_out2, hblnk_out2, vblnk_out2;
    logic [11:0] rgb_out2;
    logic [23:0] time_bcd2;

    int total_cnt = 0;
    int pass_cnt  = 0;

`ifdef RACE_TIMER_BG_EN
    localparam bit BG_ON = 1'b1;
`else
    localparam bit BG_ON = 1'b0;
`endif

    always #5 pclk = ~pclk;

    draw_race_timer dut (
        .pclk(pclk), .rst(rst),
        .hcount_in(hcount_in), .vcount_in(vcount_in),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
        .rgb_in(rgb_in), .frame_tick(frame_tick), .run(run), .clear(clear),
        .char_pixels(char_pixels), .char_addr(char_addr),
        .hcount_out(hcount_out), .vcount_out(vcount_out),
        .hsync_out(hsync_out), .vsync_out(vsync_out), .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
        .rgb_out(rgb_out), .time_bcd(time_bcd)
    );

    draw_race_timer #(.FRAMES_PER_SEC(2)) dut_sat (
        .pclk(pclk), .rst(rst),
        .hcount_in(hcount_in), .vcount_in(vcount_in),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
        .rgb_in(rgb_in), .frame_tick(frame_tick), .run(run), .clear(clear),
        .char_pixels(char_pixels2), .char_addr(char_addr2),
        .hcount_out(hcount_out2), .vcount_out(vcount_out2),
        .hsync_out(hsync_out2), .vsync_out(vsync_out2), .hblnk_out(hblnk_out2), .vblnk_out(vblnk_out2),
        .rgb_out(rgb_out2), .time_bcd(time_bcd2)
    );

    // Font model: only glyph '1' has lit pixels (10100101 on every row)
    function automatic logic [7:0] font_row(input logic [10:0] addr);
        return (addr[10:4] == 7'h31) ? 8'hA5 : 8'h00;
    endfunction

    always @(posedge pclk) char_pixels <= font_row(char_addr);

    function automatic logic [11:0] plain(input logic [11:0] rgb);
        return BG_ON ? 12'h000 : rgb;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            pass_cnt++;
            $display("ok   %s got=%h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    // Present one pixel for two cycles: char_addr checked at +1, rgb/hcount at +2
    task automatic do_pixel(input string tag, input logic [10:0] h, input logic [10:0] v,
                            input logic hb, input logic [11:0] rgb,
                            input logic [10:0] exp_addr, input logic [11:0] exp_rgb);
        hcount_in = h; vcount_in = v; hblnk_in = hb; vblnk_in = 1'b0; rgb_in = rgb;
        step();
        check_eq({tag, "_addr"}, 32'(char_addr), 32'(exp_addr));
        step();
        check_eq({tag, "_rgb"}, 32'(rgb_out), 32'(exp_rgb));
        check_eq({tag, "_hcnt"}, 32'(hcount_out), 32'(h));
    endtask

    initial begin
        // Reset with non-zero inputs so the flush is visible
        rst = 1'b1; run = 1'b1;
        hcount_in = 11'd5; vcount_in = 11'd7; hsync_in = 1'b1; rgb_in = 12'h123;
        repeat (3) step();
        check_eq("rst_rgb", 32'(rgb_out), 32'h0);
        check_eq("rst_time", 32'(time_bcd), 32'h0);
        check_eq("rst_addr", 32'(char_addr), 32'h0);
        check_eq("rst_hcnt", 32'(hcount_out), 32'h0);
        check_eq("rst_hsync", 32'(hsync_out), 32'h0);

        // Two-cycle latency of the timing bus
        rst = 1'b0;
        hcount_in = 11'd0; vcount_in = 11'd0; hsync_in = 1'b1; vsync_in = 1'b1; rgb_in = 12'h5A5;
        step();
        check_eq("lat1_hsync", 32'(hsync_out), 32'h0);
        hcount_in = 11'd1; hsync_in = 1'b0; vsync_in = 1'b0; rgb_in = 12'h111;
        step();
        check_eq("lat2_hsync", 32'(hsync_out), 32'h1);
        check_eq("lat2_vsync", 32'(vsync_out), 32'h1);
        check_eq("lat2_rgb", 32'(rgb_out), 32'h5A5);
        check_eq("lat2_hcnt", 32'(hcount_out), 32'h0);
        step();
        check_eq("lat3_hcnt", 32'(hcount_out), 32'h1);
        check_eq("lat3_hsync", 32'(hsync_out), 32'h0);

        // Counting, hold, resume
        frame_tick = 1'b1;
        repeat (61) step();
        frame_tick = 1'b0;
        check_eq("cnt61", 32'(time_bcd), 32'h000101);
        run = 1'b0;
        step();
        frame_tick = 1'b1;
        repeat (5) step();
        frame_tick = 1'b0;
        check_eq("hold5", 32'(time_bcd), 32'h000101);
        run = 1'b1;
        step();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        check_eq("resume", 32'(time_bcd), 32'h000102);

        // clear beats run and frame_tick; the IDLE->RUN cycle ignores the tick
        clear = 1'b1; frame_tick = 1'b1;
        step();
        check_eq("clear", 32'(time_bcd), 32'h0);
        clear = 1'b0;
        step();
        check_eq("entry_tick", 32'(time_bcd), 32'h0);
        step();
        frame_tick = 1'b0;
        check_eq("after_entry", 32'(time_bcd), 32'h000001);

        // Preload both instances; the 2 fps one saturates at 99:59:01 after 11999 ticks
        clear = 1'b1;
        step();
        clear = 1'b0;
        step();
        frame_tick = 1'b1;
        for (int i = 1; i <= 45296; i++) begin
            step();
            if (i == 11999) check_eq("sat_reach", 32'(time_bcd2), 32'h995901);
            if (i == 12002) check_eq("sat_hold3", 32'(time_bcd2), 32'h995901);
        end
        frame_tick = 1'b0;
        check_eq("preload", 32'(time_bcd), 32'h123456);
        check_eq("sat_final", 32'(time_bcd2), 32'h995901);

        // No vblank yet: display still shows the 00:00:00 snapshot
        do_pixel("presnap", 11'd16, 11'd16, 1'b0, 12'h0F0, 11'h300, plain(12'h0F0));

        hcount_in = 11'd0; vcount_in = 11'd0; vblnk_in = 1'b1;
        step();
        vblnk_in = 1'b0;

        do_pixel("glyph_on", 11'd16, 11'd16, 1'b0, 12'h0F0, 11'h310, 12'hFFF);
        do_pixel("glyph_off", 11'd17, 11'd16, 1'b0, 12'hABC, 11'h310, plain(12'hABC));
        do_pixel("left_out", 11'd15, 11'd16, 1'b0, 12'hABC, 11'h000, 12'hABC);
        do_pixel("colon_r3", 11'd32, 11'd19, 1'b0, 12'hABC, 11'h3A3, plain(12'hABC));
        do_pixel("right_edge", 11'd79, 11'd31, 1'b0, 12'hABC, 11'h36F, plain(12'hABC));
        do_pixel("right_out", 11'd80, 11'd31, 1'b0, 12'hABC, 11'h000, 12'hABC);
        do_pixel("below_out", 11'd16, 11'd32, 1'b0, 12'hABC, 11'h000, 12'hABC);
        do_pixel("hblnk_box", 11'd16, 11'd16, 1'b1, 12'hABC, 11'h310, 12'h000);

        // Timer moves mid-frame; digits follow only after the next vblank
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        check_eq("tick_57", 32'(time_bcd), 32'h123457);
        do_pixel("no_tear", 11'd72, 11'd16, 1'b0, 12'hABC, 11'h360, plain(12'hABC));
        vblnk_in = 1'b1;
        step();
        vblnk_in = 1'b0;
        do_pixel("new_frame", 11'd72, 11'd16, 1'b0, 12'hABC, 11'h370, plain(12'hABC));

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
